cache_mem_bridge: RTL and testbench

//  Memory-side stage directly downstream of the cache controller FSM.
//  - Accepts one 128-bit cache-line request per transaction: write-back or line fill.
//  - Serialises each line into LINE_W/WORD_W single-word transfers on a

---
 rtl/cache_mem_bridge.sv | 168 ++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_bridge.sv
// Memory-side bridge: serialises 128-bit cache-line write-backs and line fills
// into single-word valid/grant transfers, returning fills as one assembled line.
module cache_mem_bridge #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_valid_i,
  input  logic              mem_req_rw_i,
  input  logic [ADDR_W-1:0] mem_req_addr_i,
  input  logic [LINE_W-1:0] mem_req_data_i,
  output logic              mem_ready_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [WORD_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [WORD_W-1:0] bus_rdata_i
);

  localparam int BEATS   = LINE_W / WORD_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_W  = $clog2(WORD_W / 8);
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int LADDR_W = ADDR_W - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BEAT,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [LADDR_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]    wr_line_q, wr_line_d;
  logic [WORD_W-1:0]    rd_word_q [BEATS];
  logic [WORD_W-1:0]    rd_word_d [BEATS];
  logic                 overrun_q, overrun_d;

  logic [WORD_W-1:0]    wr_word [BEATS];
  logic [ADDR_W-1:0]    beat_addr;
  logic                 addr_unused;

  // Byte offset within the line carries no information for a line transfer.
  assign addr_unused = ^mem_req_addr_i[OFF_W-1:0];

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_words
    assign wr_word[gi]                      = wr_line_q[gi*WORD_W +: WORD_W];
    assign mem_data_o[gi*WORD_W +: WORD_W]  = rd_word_q[gi];
  end

  assign beat_addr = {line_q, beat_q, {BYTE_W{1'b0}}};
  assign busy_o    = (state_q != S_IDLE);
  assign overrun_o = overrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      line_q    <= '0;
      wr_line_q <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < BEATS; i++) begin
        rd_word_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      wr_line_q <= wr_line_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < BEATS; i++) begin
        rd_word_q[i] <= rd_word_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    wr_line_d   = wr_line_q;
    overrun_d   = overrun_q;
    rd_word_d   = rd_word_q;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    mem_ready_o = 1'b0;

    // A write-back cannot be posted while busy, so it is lost and flagged.
    if (mem_req_valid_i && mem_req_rw_i && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (mem_req_valid_i) begin
          line_d = mem_req_addr_i[ADDR_W-1:OFF_W];
          beat_d = '0;
          if (mem_req_rw_i) begin
            wr_line_d = mem_req_data_i;
            state_d   = S_WR_BEAT;
          end else begin
            state_d   = S_RD_REQ;
          end
        end
      end

      S_WR_BEAT: begin
        bus_req_o   = 1'b1;
        bus_we_o    = 1'b1;
        bus_addr_o  = beat_addr;
        bus_wdata_o = wr_word[beat_q];
        if (bus_gnt_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end

      S_RD_REQ: begin
        bus_req_o  = 1'b1;
        bus_addr_o = beat_addr;
        if (bus_gnt_i) begin
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        // Request stays low here so only one read word is ever outstanding.
        if (bus_rvalid_i) begin
          rd_word_d[beat_q] = bus_rdata_i;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_RESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = S_RD_REQ;
          end
        end
      end

      S_RESP: begin
        mem_ready_o = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Scoreboard bench for cache_mem_bridge: a word-bus responder model with
// programmable grant/rvalid delays, and a monitor popping expected transfers.
module tb_cache_mem_bridge;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         mem_req_valid_i;
  logic         mem_req_rw_i;
  logic [31:0]  mem_req_addr_i;
  logic [127:0] mem_req_data_i;
  logic         mem_ready_o;
  logic [127:0] mem_data_o;
  logic         busy_o;
  logic         overrun_o;
  logic         bus_req_o;
  logic         bus_we_o;
  logic [31:0]  bus_addr_o;
  logic [31:0]  bus_wdata_o;
  logic         bus_gnt_i;
  logic         bus_rvalid_i;
  logic [31:0]  bus_rdata_i;

  cache_mem_bridge dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mem_req_valid_i (mem_req_valid_i),
    .mem_req_rw_i    (mem_req_rw_i),
    .mem_req_addr_i  (mem_req_addr_i),
    .mem_req_data_i  (mem_req_data_i),
    .mem_ready_o     (mem_ready_o),
    .mem_data_o      (mem_data_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o),
    .bus_req_o       (bus_req_o),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_wdata_o     (bus_wdata_o),
    .bus_gnt_i       (bus_gnt_i),
    .bus_rvalid_i    (bus_rvalid_i),
    .bus_rdata_i     (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t         exp_bus[$];
  logic [127:0] exp_fill[$];
  logic [31:0]  rd_src[$];
  int           rv_dly_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int ready_cnt  = 0;
  int ready_cyc  = 0;
  int rd_gnt_cnt = 0;
  int gnt_delay  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder: drives gnt/rvalid 1 time unit after each rising edge.
  initial begin : responder
    int cd;
    int age;
    cd  = 0;
    age = 0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      if (cd > 0) begin
        n_checks++;
        if (bus_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL one_outstanding: bus_req_o=%0b while read pending, want 0 (cyc %0d)", bus_req_o, cyc);
        end
        cd--;
        if (cd == 0) begin
          bus_rvalid_i = 1'b1;
          if (rd_src.size() > 0) begin
            bus_rdata_i = rd_src.pop_front();
          end else begin
            n_fail++;
            $display("FAIL rd_src_empty: read data requested, none queued (cyc %0d)", cyc);
          end
        end
      end
      if (bus_req_o === 1'b1 && rst_i === 1'b0) begin
        if (age >= gnt_delay) begin
          bus_gnt_i = 1'b1;
          age = 0;
          if (bus_we_o === 1'b0) begin
            rd_gnt_cnt++;
            cd = (rv_dly_q.size() > 0) ? rv_dly_q.pop_front() : 1;
          end
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: pops expected transfers / fill lines at the falling edge.
  initial begin : monitor
    logic        held_valid;
    logic [64:0] held;
    bus_t        e;
    logic [127:0] ef;
    held_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1) begin
        held_valid = 1'b0;
      end else begin
        if (bus_req_o === 1'b1) begin
          if (held_valid) begin
            n_checks++;
            if ({bus_we_o, bus_addr_o, bus_wdata_o} !== held) begin
              n_fail++;
              $display("FAIL req_stable: got we=%0b addr=%h wdata=%h, held %h", bus_we_o, bus_addr_o, bus_wdata_o, held);
            end
          end
          if (bus_gnt_i === 1'b1) begin
            held_valid = 1'b0;
            n_checks++;
            if (exp_bus.size() == 0) begin
              n_fail++;
              $display("FAIL bus_unexpected: we=%0b addr=%h, none expected", bus_we_o, bus_addr_o);
            end else begin
              e = exp_bus.pop_front();
              if (bus_we_o !== e.we || bus_addr_o !== e.addr || (e.we && bus_wdata_o !== e.wdata)) begin
                n_fail++;
                $display("FAIL bus_xfer: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                         bus_we_o, bus_addr_o, bus_wdata_o, e.we, e.addr, e.wdata);
              end else begin
                $display("xfer we=%0b addr=%h wdata=%h cyc=%0d", bus_we_o, bus_addr_o, bus_wdata_o, cyc);
              end
            end
          end else begin
            held_valid = 1'b1;
            held = {bus_we_o, bus_addr_o, bus_wdata_o};
          end
        end else begin
          held_valid = 1'b0;
        end
        if (mem_ready_o === 1'b1) begin
          ready_cnt++;
          ready_cyc = cyc;
          n_checks++;
          if (exp_fill.size() == 0) begin
            n_fail++;
            $display("FAIL ready_unexpected: mem_data_o=%h, no fill expected", mem_data_o);
          end else begin
            ef = exp_fill.pop_front();
            if (mem_data_o !== ef) begin
              n_fail++;
              $display("FAIL fill_data: got %h want %h", mem_data_o, ef);
            end else begin
              $display("fill line=%h cyc=%0d", mem_data_o, cyc);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_ready(input int max_cyc, input string name);
    int n = 0;
    while (mem_ready_o !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: no ready after %0d cycles, want ready", name, n);
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy_o still %0b after %0d cycles, want 0", name, busy_o, n);
    end
  endtask

  task automatic push_fill(input logic [31:0] addr, input logic [31:0] seed);
    bus_t t;
    logic [127:0] line;
    for (int i = 0; i < 4; i++) begin
      t.we    = 1'b0;
      t.addr  = {addr[31:4], 4'h0} + 32'(4 * i);
      t.wdata = '0;
      exp_bus.push_back(t);
      rd_src.push_back(seed + 32'(i));
      line[i*32 +: 32] = seed + 32'(i);
    end
    exp_fill.push_back(line);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    mem_req_valid_i = 1'b0;
    mem_req_rw_i    = 1'b0;
    mem_req_addr_i  = '0;
    mem_req_data_i  = '0;
    repeat (3) tick();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    n_checks++;
    if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus_ctl: got req=%0b we=%0b want 0 0", bus_req_o, bus_we_o);
    end
    n_checks++;
    if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus_data: got addr=%h wdata=%h want 0 0", bus_addr_o, bus_wdata_o);
    end
    n_checks++;
    if (mem_ready_o !== 1'b0 || mem_data_o !== 128'h0) begin
      n_fail++; $display("FAIL reset_mem: got ready=%0b data=%h want 0 0", mem_ready_o, mem_data_o);
    end
    n_checks++;
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun_o); end
    rst_i = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fill();
    int base_rdy;
    int cap;
    gnt_delay = 0;
    push_fill(32'h0000_1234, 32'hA0A0_0000);
    base_rdy = ready_cnt;
    mem_req_addr_i  = 32'h0000_1234;
    mem_req_rw_i    = 1'b0;
    mem_req_valid_i = 1'b1;
    cap = cyc;
    tick();
    mem_req_valid_i = 1'b0;
    wait_ready(100, "fill");
    repeat (3) tick();
    n_checks++;
    if (ready_cnt - base_rdy != 1) begin
      n_fail++; $display("FAIL fill_pulses: got %0d ready pulses want 1", ready_cnt - base_rdy);
    end
    n_checks++;
    if (ready_cyc - cap != 9) begin
      n_fail++; $display("FAIL fill_latency: got %0d cycles want 9", ready_cyc - cap);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL fill_idle: busy_o=%0b want 0", busy_o); end
    $display("test_fill done");
  endtask

  task automatic test_writeback();
    bus_t t;
    int base_rdy;
    gnt_delay = 2;
    for (int i = 0; i < 4; i++) begin
      t.we    = 1'b1;
      t.addr  = 32'h0000_2000 + 32'(4 * i);
      t.wdata = 32'hD0D0_0000 + 32'(i);
      exp_bus.push_back(t);
      mem_req_data_i[i*32 +: 32] = 32'hD0D0_0000 + 32'(i);
    end
    base_rdy = ready_cnt;
    mem_req_addr_i  = 32'h0000_2000;
    mem_req_rw_i    = 1'b1;
    mem_req_valid_i = 1'b1;
    tick();
    mem_req_valid_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wb_busy: busy_o=%0b want 1", busy_o); end
    wait_idle(100, "wb");
    repeat (2) tick();
    n_checks++;
    if (ready_cnt != base_rdy) begin
      n_fail++; $display("FAIL wb_no_ready: got %0d ready pulses want 0", ready_cnt - base_rdy);
    end
    n_checks++;
    if (exp_bus.size() != 0) begin
      n_fail++; $display("FAIL wb_all_beats: %0d transfers missing want 0", exp_bus.size());
    end
    gnt_delay = 0;
    $display("test_writeback done");
  endtask

  task automatic test_wb_then_fill();
    bus_t t;
    int base_rdy;
    gnt_delay = 0;
    for (int i = 0; i < 4; i++) begin
      t.we    = 1'b1;
      t.addr  = 32'h0000_4000 + 32'(4 * i);
      t.wdata = 32'hE1E1_0000 + 32'(i);
      exp_bus.push_back(t);
      mem_req_data_i[i*32 +: 32] = 32'hE1E1_0000 + 32'(i);
    end
    push_fill(32'h0000_5010, 32'hB0B0_0010);
    base_rdy = ready_cnt;
    mem_req_addr_i  = 32'h0000_4000;
    mem_req_rw_i    = 1'b1;
    mem_req_valid_i = 1'b1;
    tick();
    mem_req_addr_i  = 32'h0000_5010;
    mem_req_rw_i    = 1'b0;
    wait_ready(100, "wbfill");
    mem_req_valid_i = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (ready_cnt - base_rdy != 1) begin
      n_fail++; $display("FAIL wbfill_pulses: got %0d ready pulses want 1", ready_cnt - base_rdy);
    end
    n_checks++;
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL wbfill_overrun: got %0b want 0", overrun_o); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wbfill_idle: busy_o=%0b want 0", busy_o); end
    $display("test_wb_then_fill done");
  endtask

  task automatic test_rvalid_delay();
    int cap;
    gnt_delay = 0;
    rv_dly_q = '{1, 1, 5, 1};
    push_fill(32'h0000_7000, 32'hC7C7_0000);
    mem_req_addr_i  = 32'h0000_7000;
    mem_req_rw_i    = 1'b0;
    mem_req_valid_i = 1'b1;
    cap = cyc;
    tick();
    mem_req_valid_i = 1'b0;
    wait_ready(100, "rvdly");
    repeat (2) tick();
    n_checks++;
    if (ready_cyc - cap != 13) begin
      n_fail++; $display("FAIL rvdly_latency: got %0d cycles want 13", ready_cyc - cap);
    end
    $display("test_rvalid_delay done");
  endtask

  task automatic test_overrun();
    int base_gnt;
    int n;
    gnt_delay = 0;
    rv_dly_q = '{3, 1, 1, 1};
    push_fill(32'h0000_6000, 32'h6060_0000);
    n_checks++;
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %0b want 0", overrun_o); end
    base_gnt = rd_gnt_cnt;
    mem_req_addr_i  = 32'h0000_6000;
    mem_req_rw_i    = 1'b0;
    mem_req_valid_i = 1'b1;
    tick();
    mem_req_valid_i = 1'b0;
    n = 0;
    while (rd_gnt_cnt == base_gnt && n < 20) begin tick(); n++; end
    tick();
    mem_req_addr_i  = 32'h0000_8000;
    mem_req_data_i  = {4{32'hBAD0_BAD0}};
    mem_req_rw_i    = 1'b1;
    mem_req_valid_i = 1'b1;
    tick();
    mem_req_valid_i = 1'b0;
    mem_req_rw_i    = 1'b0;
    n_checks++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %0b want 1", overrun_o); end
    wait_ready(100, "ovr");
    repeat (3) tick();
    n_checks++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", overrun_o); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid();
    bus_t t;
    int base_gnt;
    int base_rdy;
    int n;
    gnt_delay = 0;
    rv_dly_q = '{1, 4};
    for (int i = 0; i < 2; i++) begin
      t.we    = 1'b0;
      t.addr  = 32'h0000_3000 + 32'(4 * i);
      t.wdata = '0;
      exp_bus.push_back(t);
      rd_src.push_back(32'h5151_0000 + 32'(i));
    end
    base_gnt = rd_gnt_cnt;
    base_rdy = ready_cnt;
    mem_req_addr_i  = 32'h0000_3000;
    mem_req_rw_i    = 1'b0;
    mem_req_valid_i = 1'b1;
    tick();
    mem_req_valid_i = 1'b0;
    n = 0;
    while (rd_gnt_cnt < base_gnt + 2 && n < 30) begin tick(); n++; end
    tick();
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got busy=%0b req=%0b want 0 0", busy_o, bus_req_o);
    end
    n_checks++;
    if (overrun_o !== 1'b0 || mem_data_o !== 128'h0) begin
      n_fail++; $display("FAIL rstmid_clear: got overrun=%0b data=%h want 0 0", overrun_o, mem_data_o);
    end
    tick();
    rst_i = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (busy_o !== 1'b0 || mem_data_o !== 128'h0) begin
      n_fail++; $display("FAIL rstmid_late_rvalid: got busy=%0b data=%h want 0 0", busy_o, mem_data_o);
    end
    n_checks++;
    if (ready_cnt != base_rdy) begin
      n_fail++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", ready_cnt - base_rdy);
    end
    push_fill(32'h0000_3040, 32'hC0C0_0040);
    mem_req_addr_i  = 32'h0000_3040;
    mem_req_valid_i = 1'b1;
    tick();
    mem_req_valid_i = 1'b0;
    wait_ready(100, "rstmid_refill");
    repeat (2) tick();
    $display("test_reset_mid done");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_fill();
    test_writeback();
    test_wb_then_fill();
    test_rvalid_delay();
    test_overrun();
    test_reset_mid();
    n_checks++;
    if (exp_bus.size() != 0 || exp_fill.size() != 0 || rd_src.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left bus=%0d fill=%0d rdata=%0d want 0 0 0",
               exp_bus.size(), exp_fill.size(), rd_src.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
